// File: rtl/whirlpool_pkg.sv
// whirlpool_pkg
// Shared definitions for the Whirlpool W-cipher controller: FSM state encoding,
// default round count and round-index width.
package whirlpool_pkg;

    localparam int unsigned NUM_ROUNDS_DEF = 10;
    localparam int unsigned RIDX_W_DEF     = 4;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StLoad,
        StRound,
        StUpdate,
        StDone
    } wp_state_e;

endpackage

// File: rtl/whirlpool_round_cnt.sv
// whirlpool_round_cnt
// Round-constant index counter for the W cipher.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   i_clr   - synchronous clear to 0 (highest priority)
//   i_load  - load the counter with 1 (first round)
//   i_inc   - advance one round
//   o_cnt   - current round index
//   o_last  - current index equals NUM_ROUNDS
module whirlpool_round_cnt
    import whirlpool_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int unsigned RIDX_W     = RIDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_inc,
    output logic [RIDX_W-1:0] o_cnt,
    output logic              o_last
);

    localparam logic [RIDX_W-1:0] LastIdx = RIDX_W'(NUM_ROUNDS);

    logic [RIDX_W-1:0] r_cnt;
    logic              w_last;

    assign w_last = (r_cnt == LastIdx);

    // Stepping past the terminal count returns to 0 instead of wrapping upward,
    // so the index never exceeds NUM_ROUNDS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RIDX_W'(1);
        end else if (i_inc) begin
            r_cnt <= w_last ? '0 : r_cnt + RIDX_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;

endmodule

// File: rtl/whirlpool_wcipher_ctrl.sv
// whirlpool_wcipher_ctrl
// Control FSM for a one-round-per-cycle Whirlpool compression datapath.
// Sequence per block: IDLE -> [INIT] -> LOAD -> ROUND x NUM_ROUNDS -> UPDATE -> DONE.
// Ports:
//   clk, rst_n            - clock (rising edge), asynchronous active-low reset
//   blk_valid, blk_first  - message block offered / block starts a new message
//   blk_ready             - block accepted this cycle (IDLE only)
//   hash_init             - datapath clears H
//   load                  - datapath loads K=H, S=m^H
//   round_en, round_idx   - execute one round with round constant round_idx
//   last_round            - round_idx == NUM_ROUNDS
//   hash_upd              - datapath sets H = S^H^m
//   out_valid, out_ready  - chaining value handshake
//   busy                  - FSM is not IDLE
//   abort                 - only with WHIRLPOOL_CTRL_ABORT_EN: drop the block, return to IDLE
// Build option: define WHIRLPOOL_CTRL_ABORT_EN to add the abort input.
module whirlpool_wcipher_ctrl
    import whirlpool_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int unsigned RIDX_W     = RIDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blk_valid,
    input  logic              blk_first,
    output logic              blk_ready,
    output logic              hash_init,
    output logic              load,
    output logic              round_en,
    output logic [RIDX_W-1:0] round_idx,
    output logic              last_round,
    output logic              hash_upd,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef WHIRLPOOL_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy
);

    wp_state_e         r_state;
    wp_state_e         w_state_next;
    logic [RIDX_W-1:0] w_cnt;
    logic              w_cnt_last;
    logic              w_abort;

`ifdef WHIRLPOOL_CTRL_ABORT_EN
    assign w_abort = abort && (r_state != StIdle);
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        blk_ready    = 1'b0;
        hash_init    = 1'b0;
        load         = 1'b0;
        round_en     = 1'b0;
        hash_upd     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            StIdle: begin
                busy      = 1'b0;
                blk_ready = 1'b1;
                if (blk_valid) begin
                    w_state_next = blk_first ? StInit : StLoad;
                end
            end
            StInit: begin
                hash_init    = 1'b1;
                w_state_next = StLoad;
            end
            StLoad: begin
                load         = 1'b1;
                w_state_next = StRound;
            end
            StRound: begin
                round_en = 1'b1;
                if (w_cnt_last) begin
                    w_state_next = StUpdate;
                end
            end
            StUpdate: begin
                hash_upd     = 1'b1;
                w_state_next = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        // An aborted block must not touch H or present a result, so every
        // strobe is dropped already in the abort cycle.
        if (w_abort) begin
            w_state_next = StIdle;
            hash_init    = 1'b0;
            load         = 1'b0;
            round_en     = 1'b0;
            hash_upd     = 1'b0;
            out_valid    = 1'b0;
        end
    end

    whirlpool_round_cnt #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .RIDX_W     (RIDX_W)
    ) u_round_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_abort),
        .i_load (load),
        .i_inc  (round_en),
        .o_cnt  (w_cnt),
        .o_last (w_cnt_last)
    );

    // Index is only meaningful during a round; force 0 elsewhere.
    assign round_idx  = round_en ? w_cnt : '0;
    assign last_round = round_en & w_cnt_last;

endmodule

// File: tb/tb_whirlpool_wcipher_ctrl.sv
// Directed self-checking bench for whirlpool_wcipher_ctrl (default parameters).
module tb_whirlpool_wcipher_ctrl;

    localparam int NR = 10;

    logic       clk;
    logic       rst_n;
    logic       blk_valid;
    logic       blk_first;
    logic       blk_ready;
    logic       hash_init;
    logic       load;
    logic       round_en;
    logic [3:0] round_idx;
    logic       last_round;
    logic       hash_upd;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
`ifdef WHIRLPOOL_CTRL_ABORT_EN
    logic       abort;
`endif

    int n_vec;
    int n_fail;

    // {busy, blk_ready, hash_init, load, round_en, last_round, hash_upd, out_valid, round_idx}
    logic [11:0] obs;
    assign obs = {busy, blk_ready, hash_init, load, round_en, last_round, hash_upd, out_valid,
                  round_idx};

    localparam logic [11:0] IdleVec  = 12'b0100_0000_0000;
    localparam logic [11:0] NoRdyMsk = 12'b1011_1111_1111;

    whirlpool_wcipher_ctrl #(
        .NUM_ROUNDS (NR),
        .RIDX_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .blk_valid  (blk_valid),
        .blk_first  (blk_first),
        .blk_ready  (blk_ready),
        .hash_init  (hash_init),
        .load       (load),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .last_round (last_round),
        .hash_upd   (hash_upd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef WHIRLPOOL_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe exclusivity and round_idx range, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_vec++;
            if ($countones({hash_init, load, round_en, hash_upd}) > 1 || round_idx > 4'(NR)) begin
                n_fail++;
                $display("FAIL checker: strobes %b round_idx %0d, required one-hot-or-zero, idx<=%0d",
                         {hash_init, load, round_en, hash_upd}, round_idx, NR);
            end
        end
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_first = 1'b0;
        out_ready = 1'b0;
`ifdef WHIRLPOOL_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        #1;
        n_vec++;
        if ((obs & NoRdyMsk) !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b required %b (blk_ready ignored)", obs & NoRdyMsk,
                     12'b0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (obs !== IdleVec) begin
            n_fail++;
            $display("FAIL reset_release: got %b required %b", obs, IdleVec);
        end
    endtask

    // One block, checked cycle by cycle; 'stall' DONE cycles with out_ready=0
    // while a new block is offered that must be ignored.
    task automatic run_block(input logic first, input int stall, input string name);
        int          lat;
        int          fo;
        logic [11:0] exp;
        fo  = first ? 1 : 0;
        lat = NR + 3 + fo;
        @(negedge clk);
        n_vec++;
        if (obs !== IdleVec) begin
            n_fail++;
            $display("FAIL %s_idle: got %b required %b", name, obs, IdleVec);
        end
        blk_valid = 1'b1;
        blk_first = first;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        blk_first = ~first;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            exp = 12'b1000_0000_0000;
            if (first && k == 1) begin
                exp[9] = 1'b1;
            end else if (k == 1 + fo) begin
                exp[8] = 1'b1;
            end else if (k <= 11 + fo) begin
                exp[7]   = 1'b1;
                exp[3:0] = 4'(k - 1 - fo);
                exp[6]   = (k - 1 - fo == NR);
            end else if (k == 12 + fo) begin
                exp[5] = 1'b1;
            end else begin
                exp[4] = 1'b1;
            end
            n_vec++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b required %b", name, k, obs, exp);
            end
        end
        for (int s = 1; s <= stall; s++) begin
            blk_valid = 1'b1;
            blk_first = 1'b1;
            @(negedge clk);
            n_vec++;
            if (obs !== 12'b1000_0001_0000) begin
                n_fail++;
                $display("FAIL %s hold %0d: got %b required %b", name, s, obs,
                         12'b1000_0001_0000);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (obs !== IdleVec) begin
            n_fail++;
            $display("FAIL %s_return_idle: got %b required %b", name, obs, IdleVec);
        end
        blk_valid = 1'b0;
        blk_first = 1'b0;
    endtask

    task automatic test_first_block();
        run_block(1'b1, 0, "first_block");
    endtask

    task automatic test_non_first_block();
        run_block(1'b0, 0, "non_first_block");
    endtask

    task automatic test_backpressure();
        run_block(1'b0, 5, "backpressure");
    endtask

    task automatic test_back_to_back();
        run_block(1'b1, 0, "b2b_a");
        run_block(1'b0, 2, "b2b_b");
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        @(negedge clk);
        blk_valid = 1'b1;
        blk_first = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (round_idx == 4'd5) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_reset_wait: round_idx never reached 5 within 20 cycles");
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ((obs & NoRdyMsk) !== 12'b0) begin
            n_fail++;
            $display("FAIL mid_reset_immediate: got %b required %b", obs & NoRdyMsk, 12'b0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (obs !== IdleVec) begin
                n_fail++;
                $display("FAIL mid_reset_after %0d: got %b required %b", i, obs, IdleVec);
            end
        end
        run_block(1'b1, 0, "post_reset_block");
    endtask

`ifdef WHIRLPOOL_CTRL_ABORT_EN
    task automatic test_abort();
        bit found;
        found = 1'b0;
        @(negedge clk);
        blk_valid = 1'b1;
        blk_first = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (round_idx == 4'd7) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_wait: round_idx never reached 7 within 20 cycles");
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (obs !== IdleVec) begin
                n_fail++;
                $display("FAIL abort_idle %0d: got %b required %b", i, obs, IdleVec);
            end
        end
        run_block(1'b0, 0, "post_abort_block");
    endtask
`endif

    initial begin
        n_vec  = 0;
        n_fail = 0;
        test_reset();
        test_first_block();
        test_non_first_block();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef WHIRLPOOL_CTRL_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/whirlpool_wcipher_ctrl.md
WHIRLPOOL_WCIPHER_CTRL -- requirements
Module: whirlpool_wcipher_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, giving the number of W-cipher rounds per block.
REQ-002 The block SHALL have parameter RIDX_W, default 4, giving the width of round_idx; RIDX_W SHALL be at least clog2(NUM_ROUNDS+1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port blk_valid, input, 1 bit: a 512-bit message block is presented to the datapath.
REQ-006 The block SHALL have port blk_first, input, 1 bit: the presented block starts a new message; sampled with blk_valid.
REQ-007 The block SHALL have port blk_ready, output, 1 bit: the controller accepts a block this cycle.
REQ-008 The block SHALL have port hash_init, output, 1 bit: the datapath clears its chaining value H to zero.
REQ-009 The block SHALL have port load, output, 1 bit: the datapath loads key K=H and state S=m xor H.
REQ-010 The block SHALL have port round_en, output, 1 bit: the datapath executes one W round (gamma, pi, theta, sigma) and one key-schedule round.
REQ-011 The block SHALL have port round_idx, output, RIDX_W bits: round-constant index, 1..NUM_ROUNDS, valid while round_en is high.
REQ-012 The block SHALL have port last_round, output, 1 bit: high while round_idx equals NUM_ROUNDS.
REQ-013 The block SHALL have port hash_upd, output, 1 bit: the datapath sets H = S xor H xor m (Miyaguchi-Preneel).
REQ-014 The block SHALL have port out_valid, output, 1 bit: the chaining value H is valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the consumer accepts H.
REQ-016 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 The state machine SHALL have the states IDLE, INIT, LOAD, ROUND, UPDATE and DONE.
REQ-018 In IDLE, blk_ready SHALL be 1; a block SHALL be accepted when blk_valid and blk_ready are both 1; on acceptance the next state SHALL be INIT if blk_first is 1, otherwise LOAD.
REQ-019 INIT SHALL last 1 cycle with hash_init=1, then go to LOAD.
REQ-020 LOAD SHALL last 1 cycle with load=1, then go to ROUND with round_idx=1.
REQ-021 ROUND SHALL last exactly NUM_ROUNDS cycles with round_en=1 and round_idx incrementing 1,2,...,NUM_ROUNDS; after the last_round cycle the next state SHALL be UPDATE.
REQ-022 UPDATE SHALL last 1 cycle with hash_upd=1, then go to DONE.
REQ-023 In DONE, out_valid SHALL be 1 and held stable until out_ready is 1, then the next state SHALL be IDLE.
REQ-024 Latency from block acceptance to the first out_valid cycle SHALL be NUM_ROUNDS+3 cycles (+1 if blk_first was 1).
REQ-025 blk_ready SHALL be 0 in every state except IDLE; no block SHALL be accepted in DONE even if out_ready is 1 in the same cycle.
REQ-026 In any cycle, at most one of hash_init, load, round_en and hash_upd SHALL be 1.
REQ-027 round_idx SHALL be 0 outside ROUND and SHALL never exceed NUM_ROUNDS (no wrap-around).
REQ-028 blk_first SHALL be ignored unless a block is accepted in the same cycle.

Reset
REQ-029 While rst_n is 0, the FSM SHALL be IDLE, round_idx SHALL be 0, and busy, hash_init, load, round_en, last_round, hash_upd and out_valid SHALL be 0; blk_ready SHALL be 1 one cycle after rst_n is released.
REQ-030 Reset asserted mid-operation SHALL abandon the block immediately without asserting hash_upd or out_valid.

Configuration
REQ-031 When macro WHIRLPOOL_CTRL_ABORT_EN is defined, an input port abort (1 bit) SHALL exist; abort=1 in any non-IDLE state SHALL force IDLE on the next edge with all strobes 0 and no hash_upd or out_valid.
REQ-032 Without WHIRLPOOL_CTRL_ABORT_EN, the abort port SHALL not exist and the FSM behaviour SHALL be exactly as in REQ-017 to REQ-028.

Structure
REQ-033 Package whirlpool_pkg SHALL hold the FSM state enumeration, the NUM_ROUNDS default (10) and the round-index width constant.
REQ-034 The round counter (load to 1, increment, terminal-count last_round) SHALL be the sub-module whirlpool_round_cnt; the FSM and output decode SHALL stay in whirlpool_wcipher_ctrl.

Verification
REQ-035 Single first block: blk_valid=1, blk_first=1, out_ready=1 -> hash_init at cycle 1, load at 2, round_en at 3..12 with round_idx 1..10, hash_upd at 13, out_valid at 14.
REQ-036 Non-first block: blk_first=0 -> no hash_init; load at 1, out_valid at 13.
REQ-037 Backpressure: out_ready=0 for 5 cycles -> out_valid held 1, blk_ready 0, blk_valid ignored; release -> IDLE next cycle.
REQ-038 Mid-round reset: rst_n=0 at round_idx=5 -> all outputs reset immediately; a new block is accepted normally afterwards.
REQ-039 Abort (WHIRLPOOL_CTRL_ABORT_EN defined): abort=1 at round_idx=7 -> IDLE next cycle, no hash_upd and no out_valid.
REQ-040 A checker SHALL flag any cycle in which two strobes are 1 together, and any round_idx value above NUM_ROUNDS.
